fetch_npc_unit: RTL and testbench
=================================

Name: fetch_npc_unit

Overview:
- IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection, and IF/ID pipeline register.
- Consumes the ID-stage branch decision (Branch) and the ID-stage jump controls, and redirects fetch.
- Delayed-branch architecture: the instruction fetched behind a taken branch/jump is the delay slot and always executes; it is never flushed.
- Sits between the instruction memory (which reads PCF combinationally) and the ID stage (decoder, branch unit, register file).

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset (first fetch address).
- NOP_WORD, 32'h0000_0000, InstrD value after reset (sll $0,$0,0).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- StallF  input  1  hazard stall; holds PC and IF/ID register
- InstrF  input  32  instruction word read from IM at PCF
- Branch  input  1  ID-stage conditional branch taken
- JumpD  input  1  ID-stage j/jal
- JrD  input  1  ID-stage jr/jalr
- RsFwdD  input  32  forwarded rs value in ID (jr target)
- PCF  output  32  current fetch address to IM
- InstrD  output  32  IF/ID instruction register
- PC4D  output  32  PC of the ID instruction + 4
- PC8D  output  32  PC of the ID instruction + 8 (jal/jalr link value)
- ValidD  output  1  ID instruction is real (0 = reset bubble)
- RedirectD  output  1  next PC is not PCF+4 this cycle (debug/trace)

Behaviour:
- Reset (reset=1 at rising edge): PCF<=PC_RESET, InstrD<=NOP_WORD, PC4D<=PC_RESET, ValidD<=0. Reset overrides StallF and all redirects.
- The first rising edge after reset deassertion loads InstrD<=mem[PC_RESET], ValidD<=1.
- Next-PC (combinational), priority highest first, qualified by ValidD=1:
  - JrD: RsFwdD.
  - JumpD: {PC4D[31:28], InstrD[25:0], 2'b00}.
  - Branch: PC4D + (sign_extend(InstrD[15:0]) << 2); 32-bit wrap, no overflow trap.
  - Otherwise: PCF + 4.
- RedirectD = ValidD & ~StallF & (JrD | JumpD | Branch).
- Clocked update when StallF=0 and reset=0:
  - PCF<=NPC.
  - InstrD<=InstrF.
  - PC4D<=PCF+4.
  - ValidD<=1.
- StallF=1: PCF, InstrD, PC4D and ValidD hold. Branch, JumpD and JrD are ignored for that cycle because their operands may be stale; the redirect is taken on the first non-stalled cycle if the inputs are still asserted then.
- Multiple redirect inputs asserted together: priority as listed above; the bench flags it as a decoder error but the RTL stays deterministic.
- ValidD=0: redirects are suppressed and NPC = PCF+4.
- PC8D = PC4D + 4, combinational.
- Latency:
  - Redirect decided in cycle n takes effect as PCF at n+1.
  - The delay-slot instruction (fetched at n) reaches ID at n+1.
  - The target instruction reaches ID at n+2.
- Address width: PCF is a full 32-bit value. Misaligned JrD targets are passed through unchanged; the exception path is outside this block.
- No combinational path from InstrF to PCF.

Decomposition:
- Shared package mips_defs:
  - PC_RESET, NOP_WORD.
  - Opcode/funct constants.
  - NPC select encoding: NPC_SEQ, NPC_BR, NPC_J, NPC_JR (2-bit).
- Sub-module npc_calc: purely combinational.
  - Inputs: PCF, PC4D, InstrD, RsFwdD, select.
  - Output: NPC.
- The top module holds the PC and IF/ID registers and the priority/select logic.

Test Plan:
- Reset/sequential: reset held 2 cycles then released, IM returns distinct words -> PCF sequence 0x3000, 0x3004, 0x3008; InstrD is NOP with ValidD=0 until the first post-reset edge, then mem[0x3000].
- Taken branch with delay slot: beq at 0x3008, imm16=0x0004, Branch=1 in ID -> PCF at 0x300C (delay slot fetched), then 0x301C. Delay-slot instruction enters InstrD; RedirectD=1 for exactly one cycle.
- Backward branch wrap: branch at 0x3010, imm16=0xFFFC -> target 0x3004. At PCF=0xFFFFFFFC with sequential flow -> next PCF 0x00000000.
- Jumps: j with instr_index 0x0000C10 and PC4D=0x0000_3020 -> PCF 0x0000_3040. jal at 0x3020 -> PC8D=0x3028. jr with RsFwdD=0x0000_3100 and JumpD=1 simultaneously -> PCF 0x3100 (jr priority).
- Stall with pending branch: StallF=1 for 2 cycles while Branch=1 -> PCF, InstrD and PC4D unchanged, RedirectD=0. StallF drops with Branch=1 -> redirect to the target on that edge.
- Reset mid-operation: reset asserted in the same cycle as Branch=1 and StallF=1 -> PCF=0x3000, InstrD=NOP, ValidD=0 on the next edge.

Source files
------------

// File: rtl/fetch_npc_unit_pkg.sv
// Shared MIPS definitions for the fetch stage: reset vector, opcodes and
// the next-PC source encoding used between select logic and the calculator.
package mips_defs;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npcSel_e;

    // Word offset of a branch: sign-extended imm16 scaled to bytes.
    function automatic logic signed [31:0] branchOffset(input logic [15:0] imm);
        logic signed [31:0] ext;
        ext = {{16{imm[15]}}, imm};
        return ext <<< 2;
    endfunction

endpackage

// File: rtl/fetch_npc_unit_npc_calc.sv
// Purely combinational next-PC calculator: forms every candidate target
// and returns the one chosen by the select input.
module npc_calc
    import mips_defs::*;
(
    input  logic [31:0] pcF,
    input  logic [31:0] pc4D,
    input  logic [25:0] instrD,
    input  logic [31:0] rsFwdD,
    input  npcSel_e     sel,
    output logic [31:0] npc
);

    logic signed [31:0] brOffset;
    logic [31:0]        brTarget;
    logic [31:0]        jTarget;
    logic [31:0]        seqTarget;

    assign brOffset  = branchOffset(instrD[15:0]);
    assign brTarget  = pc4D + $unsigned(brOffset);
    assign jTarget   = {pc4D[31:28], instrD, 2'b00};
    assign seqTarget = pcF + 32'd4;

    always_comb begin
        npc = seqTarget;
        unique case (sel)
            NPC_SEQ: npc = seqTarget;
            NPC_BR:  npc = brTarget;
            NPC_J:   npc = jTarget;
            NPC_JR:  npc = rsFwdD;
            default: npc = seqTarget;
        endcase
    end

endmodule

// File: rtl/fetch_npc_unit.sv
// IF stage: PC register, prioritised next-PC selection and the IF/ID
// register. Delayed-branch: the slot behind a redirect is never flushed.
module fetch_npc_unit
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET = mips_defs::PC_RESET,
    parameter logic [31:0] NOP_WORD = mips_defs::NOP_WORD
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic [31:0] InstrF,
    input  logic        Branch,
    input  logic        JumpD,
    input  logic        JrD,
    input  logic [31:0] RsFwdD,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PC4D,
    output logic [31:0] PC8D,
    output logic        ValidD,
    output logic        RedirectD
);

    npcSel_e     npcSel;
    logic [31:0] npc;
    logic [31:0] pcSeq;

    assign pcSeq = PCF + 32'd4;
    assign PC8D  = PC4D + 32'd4;

    // Redirects only count for a real ID instruction; jr beats j beats branch.
    always_comb begin
        npcSel = NPC_SEQ;
        if (ValidD) begin
            if (JrD)
                npcSel = NPC_JR;
            else if (JumpD)
                npcSel = NPC_J;
            else if (Branch)
                npcSel = NPC_BR;
        end
    end

    assign RedirectD = ValidD & ~StallF & (JrD | JumpD | Branch);

    npc_calc uNpcCalc (
        .pcF    (PCF),
        .pc4D   (PC4D),
        .instrD (InstrD[25:0]),
        .rsFwdD (RsFwdD),
        .sel    (npcSel),
        .npc    (npc)
    );

    // A stall freezes everything, so stale redirect operands are never used.
    always_ff @(posedge clk) begin
        if (reset) begin
            PCF    <= PC_RESET;
            InstrD <= NOP_WORD;
            PC4D   <= PC_RESET;
            ValidD <= 1'b0;
        end else if (!StallF) begin
            PCF    <= npc;
            InstrD <= InstrF;
            PC4D   <= pcSeq;
            ValidD <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Directed and randomized checks of fetch_npc_unit against a behavioural
// model of the fetch stage (PC, IF/ID contents and redirect decision).
module tb_fetch_npc_unit;

    logic        clk = 1'b0;
    logic        reset, StallF, Branch, JumpD, JrD;
    logic [31:0] InstrF, RsFwdD;
    logic [31:0] PCF, InstrD, PC4D, PC8D;
    logic        ValidD, RedirectD;

    int vecs = 0;
    int miss = 0;
    int multiRedirect = 0;

    // Reference state of the fetch stage
    logic [31:0] mPC = 32'h0, mInstr = 32'h0, mPC4 = 32'h0;
    logic        mValid = 1'b0;
    // Values observed just before the most recent edge
    logic        obsRedirect, expRedirect;
    logic [31:0] obsPC8;

    fetch_npc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .InstrF    (InstrF),
        .Branch    (Branch),
        .JumpD     (JumpD),
        .JrD       (JrD),
        .RsFwdD    (RsFwdD),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PC4D      (PC4D),
        .PC8D      (PC8D),
        .ValidD    (ValidD),
        .RedirectD (RedirectD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    // Drive one cycle of inputs, record pre-edge outputs, advance model and clock.
    task automatic tick(input logic rst, input logic stall, input logic br, input logic j,
                        input logic jr, input logic [31:0] instr, input logic [31:0] rs);
        logic [31:0] target;
        reset = rst; StallF = stall; Branch = br; JumpD = j; JrD = jr;
        InstrF = instr; RsFwdD = rs;
        #1;
        obsRedirect = RedirectD;
        obsPC8      = PC8D;
        expRedirect = mValid && !stall && (br || j || jr);
        if (mValid && ((br && j) || (br && jr) || (j && jr))) multiRedirect++;
        if (rst) begin
            mPC = 32'h0000_3000; mInstr = 32'h0; mPC4 = 32'h0000_3000; mValid = 1'b0;
        end else if (!stall) begin
            if (mValid && jr)      target = rs;
            else if (mValid && j)  target = {mPC4[31:28], mInstr[25:0], 2'b00};
            else if (mValid && br) target = mPC4 + 32'($signed(mInstr[15:0]) * 4);
            else                   target = mPC + 32'd4;
            mInstr = instr; mPC4 = mPC + 32'd4; mValid = 1'b1; mPC = target;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] w0, w1;
        tick(1, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
        tick(1, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
        vecs++; if (PCF !== 32'h3000) begin miss++; $display("FAIL reset_pcf got %h want %h", PCF, 32'h3000); end
        vecs++; if (InstrD !== 32'h0) begin miss++; $display("FAIL reset_instr got %h want %h", InstrD, 32'h0); end
        vecs++; if (PC4D !== 32'h3000) begin miss++; $display("FAIL reset_pc4 got %h want %h", PC4D, 32'h3000); end
        vecs++; if (ValidD !== 1'b0) begin miss++; $display("FAIL reset_valid got %b want 0", ValidD); end
        w0 = memWord(32'h3000);
        tick(0, 0, 0, 0, 0, w0, 0);
        vecs++; if (PCF !== 32'h3004) begin miss++; $display("FAIL seq1_pcf got %h want %h", PCF, 32'h3004); end
        vecs++; if (InstrD !== w0) begin miss++; $display("FAIL seq1_instr got %h want %h", InstrD, w0); end
        vecs++; if (ValidD !== 1'b1) begin miss++; $display("FAIL seq1_valid got %b want 1", ValidD); end
        w1 = memWord(32'h3004);
        tick(0, 0, 0, 0, 0, w1, 0);
        vecs++; if (PCF !== 32'h3008) begin miss++; $display("FAIL seq2_pcf got %h want %h", PCF, 32'h3008); end
        vecs++; if (InstrD !== w1) begin miss++; $display("FAIL seq2_instr got %h want %h", InstrD, w1); end
    endtask

    task automatic test_branch;
        logic [31:0] beq, ds;
        beq = {6'h04, 5'd1, 5'd2, 16'h0004};
        ds  = memWord(32'h300C);
        tick(0, 0, 0, 0, 0, beq, 0);
        vecs++; if (PCF !== 32'h300C) begin miss++; $display("FAIL br_slot_pcf got %h want %h", PCF, 32'h300C); end
        vecs++; if (PC4D !== 32'h300C) begin miss++; $display("FAIL br_pc4 got %h want %h", PC4D, 32'h300C); end
        tick(0, 0, 1, 0, 0, ds, 0);
        vecs++; if (obsRedirect !== 1'b1) begin miss++; $display("FAIL br_redirect got %b want 1", obsRedirect); end
        vecs++; if (PCF !== 32'h301C) begin miss++; $display("FAIL br_target got %h want %h", PCF, 32'h301C); end
        vecs++; if (InstrD !== ds) begin miss++; $display("FAIL br_delayslot got %h want %h", InstrD, ds); end
        tick(0, 0, 0, 0, 0, memWord(32'h301C), 0);
        vecs++; if (obsRedirect !== 1'b0) begin miss++; $display("FAIL br_redirect_once got %b want 0", obsRedirect); end
        vecs++; if (PCF !== 32'h3020) begin miss++; $display("FAIL br_after got %h want %h", PCF, 32'h3020); end
    endtask

    task automatic test_backward_wrap;
        tick(0, 0, 0, 0, 1, memWord(mPC), 32'h3010);
        vecs++; if (PCF !== 32'h3010) begin miss++; $display("FAIL jr3010 got %h want %h", PCF, 32'h3010); end
        tick(0, 0, 0, 0, 0, {6'h05, 5'd3, 5'd4, 16'hFFFC}, 0);
        tick(0, 0, 1, 0, 0, memWord(32'h3014), 0);
        vecs++; if (PCF !== 32'h3004) begin miss++; $display("FAIL back_br got %h want %h", PCF, 32'h3004); end
        tick(0, 0, 0, 0, 1, memWord(mPC), 32'hFFFF_FFFC);
        vecs++; if (PCF !== 32'hFFFF_FFFC) begin miss++; $display("FAIL jr_top got %h want %h", PCF, 32'hFFFF_FFFC); end
        tick(0, 0, 0, 0, 0, memWord(32'hFFFF_FFFC), 0);
        vecs++; if (PCF !== 32'h0) begin miss++; $display("FAIL wrap_pcf got %h want %h", PCF, 32'h0); end
        vecs++; if (PC4D !== 32'h0) begin miss++; $display("FAIL wrap_pc4 got %h want %h", PC4D, 32'h0); end
    endtask

    task automatic test_jumps;
        logic [31:0] jw, jalw;
        jw   = {6'h02, 26'h000_0C10};
        jalw = {6'h03, 26'h000_0D00};
        tick(0, 0, 0, 0, 1, memWord(mPC), 32'h301C);
        tick(0, 0, 0, 0, 0, jw, 0);
        vecs++; if (PC4D !== 32'h3020) begin miss++; $display("FAIL j_pc4 got %h want %h", PC4D, 32'h3020); end
        tick(0, 0, 0, 1, 0, jalw, 0);
        vecs++; if (obsRedirect !== 1'b1) begin miss++; $display("FAIL j_redirect got %b want 1", obsRedirect); end
        vecs++; if (PCF !== 32'h3040) begin miss++; $display("FAIL j_target got %h want %h", PCF, 32'h3040); end
        vecs++; if (PC8D !== 32'h3028) begin miss++; $display("FAIL jal_pc8 got %h want %h", PC8D, 32'h3028); end
        tick(0, 0, 0, 1, 1, memWord(32'h3040), 32'h3100);
        vecs++; if (PCF !== 32'h3100) begin miss++; $display("FAIL jr_priority got %h want %h", PCF, 32'h3100); end
    endtask

    task automatic test_stall;
        logic [31:0] beq;
        beq = {6'h04, 5'd5, 5'd6, 16'h0010};
        tick(0, 0, 0, 0, 1, memWord(mPC), 32'h3040);
        tick(0, 0, 0, 0, 0, beq, 0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 1, 1, 0, 0, $urandom, 0);
            vecs++; if (obsRedirect !== 1'b0) begin miss++; $display("FAIL stall_redirect[%0d] got %b want 0", i, obsRedirect); end
            vecs++; if (PCF !== 32'h3044) begin miss++; $display("FAIL stall_pcf[%0d] got %h want %h", i, PCF, 32'h3044); end
            vecs++; if (InstrD !== beq) begin miss++; $display("FAIL stall_instr[%0d] got %h want %h", i, InstrD, beq); end
            vecs++; if (PC4D !== 32'h3044) begin miss++; $display("FAIL stall_pc4[%0d] got %h want %h", i, PC4D, 32'h3044); end
        end
        tick(0, 0, 1, 0, 0, memWord(32'h3044), 0);
        vecs++; if (obsRedirect !== 1'b1) begin miss++; $display("FAIL unstall_redirect got %b want 1", obsRedirect); end
        vecs++; if (PCF !== 32'h3084) begin miss++; $display("FAIL unstall_target got %h want %h", PCF, 32'h3084); end
    endtask

    task automatic test_reset_mid;
        tick(1, 1, 1, 0, 0, $urandom, 0);
        vecs++; if (PCF !== 32'h3000) begin miss++; $display("FAIL midrst_pcf got %h want %h", PCF, 32'h3000); end
        vecs++; if (InstrD !== 32'h0) begin miss++; $display("FAIL midrst_instr got %h want %h", InstrD, 32'h0); end
        vecs++; if (ValidD !== 1'b0) begin miss++; $display("FAIL midrst_valid got %b want 0", ValidD); end
        tick(0, 0, 1, 1, 1, memWord(32'h3000), 32'h0000_7770);
        vecs++; if (obsRedirect !== 1'b0) begin miss++; $display("FAIL bubble_redirect got %b want 0", obsRedirect); end
        vecs++; if (PCF !== 32'h3004) begin miss++; $display("FAIL bubble_pcf got %h want %h", PCF, 32'h3004); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), $urandom, $urandom);
            vecs++; if (obsRedirect !== expRedirect) begin miss++; $display("FAIL rnd_redirect[%0d] got %b want %b", i, obsRedirect, expRedirect); end
            vecs++; if (PCF !== mPC) begin miss++; $display("FAIL rnd_pcf[%0d] got %h want %h", i, PCF, mPC); end
            vecs++; if (InstrD !== mInstr) begin miss++; $display("FAIL rnd_instr[%0d] got %h want %h", i, InstrD, mInstr); end
            vecs++; if (PC4D !== mPC4) begin miss++; $display("FAIL rnd_pc4[%0d] got %h want %h", i, PC4D, mPC4); end
            vecs++; if (ValidD !== mValid) begin miss++; $display("FAIL rnd_valid[%0d] got %b want %b", i, ValidD, mValid); end
            vecs++; if (PC8D !== mPC4 + 32'd4) begin miss++; $display("FAIL rnd_pc8[%0d] got %h want %h", i, PC8D, mPC4 + 32'd4); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_branch;
        test_backward_wrap;
        test_jumps;
        test_stall;
        test_reset_mid;
        test_random;
        $display("note: %0d cycles with conflicting redirect inputs (decoder error)", multiRedirect);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
